adc_acq_ctrl: RTL and testbench
===============================

ADC_ACQ_CTRL -- requirements
Module: adc_acq_ctrl

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-002 The block SHALL have port `reset_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port `RestartReq`, input, 1 bit: single-cycle start/restart pulse from the command decoder.
REQ-004 The block SHALL have port `ChannelSel`, input, 2 bits: 00 disabled, 01 channel A, 10 channel B, 11 both.
REQ-005 The block SHALL have port `DataNum`, input, 32 bits: number of sample ticks per acquisition.
REQ-006 The block SHALL have port `ADC_Speed_Set`, input, 32 bits: sample period minus 1, in clk cycles.
REQ-007 The block SHALL have ports `adc_data_a` and `adc_data_b`, input, 16 bits each: ADC output buses.
REQ-008 The block SHALL have port `adc_sample`, output, 1 bit: one-cycle ADC conversion strobe.
REQ-009 The block SHALL have port `out_valid`, output, 1 bit: `out_data` holds a word.
REQ-010 The block SHALL have port `out_ready`, input, 1 bit: downstream FIFO accepts the word.
REQ-011 The block SHALL have port `out_data`, output, 32 bits: packed sample word.
REQ-012 The block SHALL have port `busy`, output, 1 bit: acquisition in progress.
REQ-013 The block SHALL have port `done`, output, 1 bit: one-cycle pulse at completion.
REQ-014 The block SHALL have port `sample_cnt`, output, 32 bits: ticks issued in the current acquisition.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DRAIN.
REQ-016 On `RestartReq`=1 in any state, the block SHALL latch `ChannelSel`, `DataNum` and `ADC_Speed_Set`, clear `sample_cnt`, the period counter and any pending output, and go to RUN next cycle. If latched `ChannelSel`=00 or `DataNum`=0, it SHALL instead go to IDLE and pulse `done`.
REQ-017 In RUN, the first `adc_sample` SHALL occur in the first RUN cycle; subsequent strobes SHALL be spaced exactly `ADC_Speed_Set`+1 cycles; `ADC_Speed_Set`=0 SHALL give a strobe every cycle.
REQ-018 Each `adc_sample` SHALL increment `sample_cnt` in the same edge; after the strobe making `sample_cnt`=`DataNum`, the block SHALL go to DRAIN.
REQ-019 ADC data SHALL be captured exactly 2 cycles after the corresponding `adc_sample`, using a fixed-length 2-stage capture pipeline.
REQ-020 Packing SHALL be: 01 -> {16'h0000, A}; 10 -> {16'h0000, B}; 11 -> {B, A}.
REQ-021 `out_valid` SHALL rise on capture and hold with `out_data` stable until `out_valid`&&`out_ready`; a transfer and a new capture in the same cycle SHALL load the new word with `out_valid` staying 1.
REQ-022 DRAIN SHALL wait until all captures have completed and the last word is transferred, then pulse `done` for one cycle and enter IDLE.
REQ-023 `busy` SHALL be 1 in RUN and DRAIN, and 0 in IDLE.
REQ-024 `sample_cnt` SHALL hold its final value in IDLE until the next restart.
REQ-025 Input changes outside a `RestartReq` cycle SHALL have no effect on a running acquisition.

Reset
REQ-026 Asserting `reset_n` low SHALL immediately force IDLE and force `adc_sample`, `out_valid`, `busy`, `done`, `out_data`, `sample_cnt` and the latched config to 0, including mid-acquisition; the capture pipeline SHALL be flushed.

Configuration
REQ-027 Macro `ACQ_OVERRUN_EN` SHALL select overrun behaviour: if undefined, a due tick whose capture would find `out_valid`=1 with no transfer SHALL be deferred (period counter holds) until space exists, so no sample is lost.
REQ-028 If `ACQ_OVERRUN_EN` is defined, ticks SHALL never be deferred; a capture colliding with an untransferred word SHALL be dropped (pending word kept), the drop still SHALL count toward `DataNum`, and an extra output `overrun_cnt` (16-bit, saturating at 16'hFFFF, cleared on restart/reset) SHALL count drops.

Verification
REQ-029 Verification SHALL cover: `ChannelSel`=01, `DataNum`=4, `ADC_Speed_Set`=9, `out_ready`=1, restart -> 4 strobes 10 cycles apart, 4 words {0,A}, `done` once, `sample_cnt`=4.
REQ-030 Verification SHALL cover: `ChannelSel`=11, `ADC_Speed_Set`=0, `DataNum`=3, A=16'h1234, B=16'hABCD -> 3 consecutive words 32'hABCD1234.
REQ-031 Verification SHALL cover: restart with `DataNum`=0 (or `ChannelSel`=00) -> no strobe, `done` pulse 1 cycle later, `busy` stays 0.
REQ-032 Verification SHALL cover: `DataNum`=100, second `RestartReq` at `sample_cnt`=37 -> `sample_cnt` back to 0, 100 further strobes, single `done`.
REQ-033 Verification SHALL cover: `out_ready`=0 for 50 cycles, `ADC_Speed_Set`=0, `DataNum`=8 -> without macro, all 8 words are delivered in order with stalled strobes; with macro, 8 strobes occur back-to-back and `overrun_cnt`=7.
REQ-034 Verification SHALL cover: `reset_n` pulsed low mid-RUN -> all outputs 0 asynchronously; no `done` and no stale word after release.

Source files
------------

// File: rtl/adc_acq_ctrl.sv
// adc_acq_ctrl: sample-acquisition sequencer for a dual-channel ADC.
//
// A RestartReq pulse latches the channel/length/period configuration and
// starts an acquisition. In RUN the block issues adc_sample strobes every
// ADC_Speed_Set+1 cycles. Each strobe's data is captured two cycles later and
// packed into a 32-bit word on a valid/ready output. DRAIN waits for the last
// capture to be delivered, then done pulses and the block returns to IDLE.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   RestartReq              start/restart pulse (latches ChannelSel/DataNum/ADC_Speed_Set)
//   ChannelSel[1:0]         00 off, 01 A, 10 B, 11 both
//   DataNum[31:0]           sample ticks per acquisition
//   ADC_Speed_Set[31:0]     sample period minus one
//   adc_data_a/b[15:0]      ADC buses
//   adc_sample              conversion strobe
//   out_valid/out_ready/out_data[31:0]  packed sample word stream
//   busy, done, sample_cnt[31:0]        status
//   overrun_cnt[15:0]       dropped captures (only with ACQ_OVERRUN_EN)
//
// Build option: define ACQ_OVERRUN_EN to never stall ticks and drop captures
// that collide with an untransferred word. Without it, ticks are held back
// until the capture is guaranteed a slot, so no sample is lost.
module adc_acq_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        RestartReq,
    input  logic [1:0]  ChannelSel,
    input  logic [31:0] DataNum,
    input  logic [31:0] ADC_Speed_Set,
    input  logic [15:0] adc_data_a,
    input  logic [15:0] adc_data_b,
    input  logic        out_ready,
`ifdef ACQ_OVERRUN_EN
    output logic [15:0] overrun_cnt,
`endif
    output logic        adc_sample,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] sample_cnt
);

    // Output word storage: entry 0 is the word on out_data; the others are a
    // skid that absorbs captures already in the 2-stage pipe when the
    // downstream stalls.
`ifdef ACQ_OVERRUN_EN
    localparam int DEPTH = 1;
`else
    localparam int DEPTH = 3;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state, state_n;
    logic [1:0]              cfg_ch;
    logic [31:0]             cfg_num;
    logic [31:0]             cfg_spd;
    logic [31:0]             pcnt;
    logic [1:0]              vld_pipe;
    logic [DEPTH-1:0][31:0]  q, q_n;
    logic [1:0]              q_cnt, cnt_n;
    logic                    done_n;
    logic                    xfer;
    logic                    cap_ok;
    logic                    room;
    logic [2:0]              occ;
    logic [31:0]             cap_word;

    assign out_valid = (q_cnt != 2'd0);
    assign out_data  = q[0];
    assign busy      = (state != IDLE);
    assign xfer      = out_valid && out_ready;

    always_comb begin
        case (cfg_ch)
            2'b01:   cap_word = {16'h0000, adc_data_a};
            2'b10:   cap_word = {16'h0000, adc_data_b};
            default: cap_word = {adc_data_b, adc_data_a};
        endcase
    end

    // Every word already stored or still in flight will need a slot; a new
    // tick is allowed only if its capture is guaranteed one.
    assign occ = {1'b0, q_cnt} + {2'b00, vld_pipe[0]} + {2'b00, vld_pipe[1]}
                 - {2'b00, xfer};
`ifdef ACQ_OVERRUN_EN
    assign room = 1'b1;
`else
    assign room = (occ <= 3'(DEPTH - 1));
`endif

    assign adc_sample = (state == RUN) && (pcnt == 32'd0) && room && !RestartReq;

    // Word store: pop on transfer, then append the capture behind it.
    always_comb begin
        q_n   = q;
        cnt_n = q_cnt;
        if (xfer) begin
            for (int i = 0; i < DEPTH - 1; i++) q_n[i] = q[i+1];
            cnt_n = q_cnt - 2'd1;
        end
        cap_ok = vld_pipe[1] && (cnt_n < 2'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            if (cap_ok && (cnt_n == 2'(i))) q_n[i] = cap_word;
        end
        if (cap_ok) cnt_n = cnt_n + 2'd1;
    end

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        if (RestartReq) begin
            if (ChannelSel == 2'b00 || DataNum == 32'd0) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (adc_sample && (sample_cnt + 32'd1 == cfg_num)) state_n = DRAIN;
                end
                DRAIN: begin
                    // pipe stage 1 has landed in cnt_n; only stage 0 is still out
                    if (!vld_pipe[0] && cnt_n == 2'd0) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            cfg_ch     <= 2'b00;
            cfg_num    <= 32'd0;
            cfg_spd    <= 32'd0;
            pcnt       <= 32'd0;
            sample_cnt <= 32'd0;
            vld_pipe   <= 2'b00;
            q          <= '0;
            q_cnt      <= 2'd0;
        end else begin
            state <= state_n;
            done  <= done_n;
            if (RestartReq) begin
                cfg_ch     <= ChannelSel;
                cfg_num    <= DataNum;
                cfg_spd    <= ADC_Speed_Set;
                pcnt       <= 32'd0;
                sample_cnt <= 32'd0;
                vld_pipe   <= 2'b00;
                q          <= '0;
                q_cnt      <= 2'd0;
            end else begin
                vld_pipe <= {vld_pipe[0], adc_sample};
                q        <= q_n;
                q_cnt    <= cnt_n;
                // a deferred tick leaves pcnt at 0 so it fires as soon as room exists
                if (adc_sample) begin
                    sample_cnt <= sample_cnt + 32'd1;
                    pcnt       <= cfg_spd;
                end else if (state == RUN && pcnt != 32'd0) begin
                    pcnt <= pcnt - 32'd1;
                end
            end
        end
    end

`ifdef ACQ_OVERRUN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_cnt <= 16'h0000;
        end else if (RestartReq) begin
            overrun_cnt <= 16'h0000;
        end else if (vld_pipe[1] && !cap_ok && overrun_cnt != 16'hFFFF) begin
            overrun_cnt <= overrun_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// Directed self-checking bench for adc_acq_ctrl (default and ACQ_OVERRUN_EN builds).
module tb_adc_acq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        RestartReq = 1'b0;
    logic [1:0]  ChannelSel = 2'b00;
    logic [31:0] DataNum = 32'd0;
    logic [31:0] ADC_Speed_Set = 32'd0;
    logic [15:0] a_fix = 16'h0000;
    logic [15:0] adc_data_b = 16'h0000;
    logic [15:0] adc_data_a;
    logic [15:0] ramp = 16'h0000;
    logic        ramp_mode = 1'b0;
    logic        out_ready = 1'b1;
    logic        adc_sample;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic [31:0] sample_cnt;
`ifdef ACQ_OVERRUN_EN
    logic [15:0] overrun_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // monitor state
    int          cyc = 0;
    int          done_cnt = 0;
    int          rs_cyc = 0;
    int          strobe_t[$];
    logic [31:0] word_q[$];
    logic [31:0] exp_q[$];

    assign adc_data_a = ramp_mode ? ramp : a_fix;

    always #5 clk = ~clk;

    adc_acq_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .RestartReq    (RestartReq),
        .ChannelSel    (ChannelSel),
        .DataNum       (DataNum),
        .ADC_Speed_Set (ADC_Speed_Set),
        .adc_data_a    (adc_data_a),
        .adc_data_b    (adc_data_b),
        .out_ready     (out_ready),
`ifdef ACQ_OVERRUN_EN
        .overrun_cnt   (overrun_cnt),
`endif
        .adc_sample    (adc_sample),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .busy          (busy),
        .done          (done),
        .sample_cnt    (sample_cnt)
    );

    // Ramp source: the DUT samples the pre-edge value, so a strobe seen with
    // ramp=R is captured two edges later with ramp=R+2.
    always @(posedge clk) ramp <= ramp + 16'd1;

    always @(posedge clk) begin
        if (reset_n) begin
            cyc = cyc + 1;
            if (RestartReq) rs_cyc = cyc;
            if (adc_sample) begin
                strobe_t.push_back(cyc);
                exp_q.push_back({16'h0000, ramp + 16'd2});
            end
            if (out_valid && out_ready) word_q.push_back(out_data);
            if (done) done_cnt = done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the restart edge
    task automatic restart(input logic [1:0] ch, input logic [31:0] num, input logic [31:0] spd);
        ChannelSel    = ch;
        DataNum       = num;
        ADC_Speed_Set = spd;
        RestartReq    = 1'b1;
        @(negedge clk);
        RestartReq    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    initial begin
        int s0, w0, d0, e0, n, nw;

        // reset state
        #1 reset_n = 1'b0;
        #2;
        chk("rst_sample",  32'(adc_sample), 32'd0);
        chk("rst_valid",   32'(out_valid),  32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_done",    32'(done),       32'd0);
        chk("rst_data",    out_data,        32'd0);
        chk("rst_cnt",     sample_cnt,      32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // A only, 4 samples, period 10
        a_fix = 16'h1111; adc_data_b = 16'h2222; out_ready = 1'b1;
        s0 = strobe_t.size(); w0 = word_q.size(); d0 = done_cnt;
        restart(2'b01, 32'd4, 32'd9);
        chk("t2_busy", 32'(busy), 32'd1);
        wait_done("t2_done_seen", 200, d0);
        chk("t2_strobes", 32'(strobe_t.size() - s0), 32'd4);
        if (strobe_t.size() - s0 == 4) begin
            chk("t2_first", 32'(strobe_t[s0] - rs_cyc), 32'd1);
            for (int i = 1; i < 4; i++)
                chk("t2_gap", 32'(strobe_t[s0+i] - strobe_t[s0+i-1]), 32'd10);
        end
        chk("t2_words", 32'(word_q.size() - w0), 32'd4);
        nw = word_q.size() - w0;
        for (int i = 0; i < nw && i < 4; i++) chk("t2_word", word_q[w0+i], 32'h0000_1111);
        chk("t2_cnt", sample_cnt, 32'd4);
        chk("t2_busy_end", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("t2_done_once", 32'(done_cnt - d0), 32'd1);

        // both channels, back-to-back strobes
        a_fix = 16'h1234; adc_data_b = 16'hABCD;
        s0 = strobe_t.size(); w0 = word_q.size(); d0 = done_cnt;
        restart(2'b11, 32'd3, 32'd0);
        wait_done("t3_done_seen", 100, d0);
        chk("t3_strobes", 32'(strobe_t.size() - s0), 32'd3);
        if (strobe_t.size() - s0 == 3) begin
            chk("t3_gap1", 32'(strobe_t[s0+1] - strobe_t[s0]), 32'd1);
            chk("t3_gap2", 32'(strobe_t[s0+2] - strobe_t[s0+1]), 32'd1);
        end
        chk("t3_words", 32'(word_q.size() - w0), 32'd3);
        nw = word_q.size() - w0;
        for (int i = 0; i < nw && i < 3; i++) chk("t3_word", word_q[w0+i], 32'hABCD_1234);
        @(negedge clk);

        // degenerate restarts
        s0 = strobe_t.size();
        restart(2'b01, 32'd0, 32'd5);
        chk("t4_done_num0", 32'(done), 32'd1);
        chk("t4_busy_num0", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_done_drop", 32'(done), 32'd0);
        chk("t4_busy_after", 32'(busy), 32'd0);
        restart(2'b00, 32'd5, 32'd0);
        chk("t4_done_ch0", 32'(done), 32'd1);
        chk("t4_busy_ch0", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t4_no_strobe", 32'(strobe_t.size() - s0), 32'd0);

        // restart mid-run, then ignore config changes without restart
        d0 = done_cnt;
        restart(2'b01, 32'd100, 32'd0);
        n = 0;
        while (sample_cnt != 32'd37 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach37", sample_cnt, 32'd37);
        s0 = strobe_t.size();
        restart(2'b01, 32'd100, 32'd0);
        chk("t5_cnt_clr", sample_cnt, 32'd0);
        ChannelSel = 2'b00; DataNum = 32'd5; ADC_Speed_Set = 32'd7;
        wait_done("t5_done_seen", 500, d0);
        chk("t5_strobes", 32'(strobe_t.size() - s0), 32'd100);
        chk("t5_cnt", sample_cnt, 32'd100);
        repeat (3) @(negedge clk);
        chk("t5_done_once", 32'(done_cnt - d0), 32'd1);

        // downstream stall for 50 cycles with ramped data
        ramp_mode = 1'b1; out_ready = 1'b0;
        s0 = strobe_t.size(); w0 = word_q.size(); e0 = exp_q.size(); d0 = done_cnt;
        restart(2'b01, 32'd8, 32'd0);
        repeat (50) @(negedge clk);
`ifdef ACQ_OVERRUN_EN
        chk("t6_strobes_stall", 32'(strobe_t.size() - s0), 32'd8);
        chk("t6_overrun", 32'(overrun_cnt), 32'd7);
`else
        chk("t6_strobes_stall", 32'(strobe_t.size() - s0), 32'd3);
`endif
        chk("t6_valid_held", 32'(out_valid), 32'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        if (exp_q.size() > e0) chk("t6_data_held", out_data, exp_q[e0]);
        out_ready = 1'b1;
        wait_done("t6_done_seen", 200, d0);
        chk("t6_strobes", 32'(strobe_t.size() - s0), 32'd8);
        nw = word_q.size() - w0;
`ifdef ACQ_OVERRUN_EN
        chk("t6_words", 32'(nw), 32'd1);
        if (nw >= 1) chk("t6_word0", word_q[w0], exp_q[e0]);
`else
        chk("t6_words", 32'(nw), 32'd8);
        for (int i = 0; i < nw && i < 8; i++) chk("t6_word", word_q[w0+i], exp_q[e0+i]);
`endif
        ramp_mode = 1'b0;
        @(negedge clk);

        // asynchronous reset in the middle of RUN
        a_fix = 16'h0005;
        restart(2'b01, 32'd50, 32'd3);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t7_sample", 32'(adc_sample), 32'd0);
        chk("t7_valid",  32'(out_valid),  32'd0);
        chk("t7_busy",   32'(busy),       32'd0);
        chk("t7_done",   32'(done),       32'd0);
        chk("t7_data",   out_data,        32'd0);
        chk("t7_cnt",    sample_cnt,      32'd0);
        d0 = done_cnt; w0 = word_q.size(); s0 = strobe_t.size();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t7_no_done",   32'(done_cnt - d0),         32'd0);
        chk("t7_no_word",   32'(word_q.size() - w0),    32'd0);
        chk("t7_no_strobe", 32'(strobe_t.size() - s0),  32'd0);
        chk("t7_idle_busy", 32'(busy),                  32'd0);
        chk("t7_idle_cnt",  sample_cnt,                 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
